// File: rtl/blackjack_pkg.sv
// Shared constants and encodings for the blackjack controller and scoring block.
package blackjack_pkg;

  localparam int unsigned PTS_W                = 6;
  localparam logic [5:0]  BLACKJACK            = 6'd21;
  localparam int unsigned LIMIAR_DEALER_PADRAO = 17;
  localparam int unsigned TIMEOUT_PADRAO       = 64;

  typedef enum logic [3:0] {
    E_IDLE,
    E_LIMPA,
    E_DISTRIBUI,
    E_VEZ_JOG,
    E_CARTA_JOG,
    E_VEZ_DEALER,
    E_CARTA_DEALER,
    E_COMPARA,
    E_RESULTADO
  } estado_t;

  typedef enum logic [1:0] {
    P_OCIOSO,
    P_ESPERA_BAIXO,
    P_PEDE,
    P_SOLTA
  } pedido_t;

  typedef struct packed {
    logic vitoria;
    logic derrota;
    logic empate;
    logic erro;
  } resultado_t;

endpackage

// File: rtl/blackjack_controle_pedido_carta.sv
// One card request over the pjogador/pdealer/cartaok handshake, with timeout watchdog.
module pedido_carta
  import blackjack_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic go,
  input  logic quem,
  input  logic cartaok,
  output logic pjogador,
  output logic pdealer,
  output logic feito,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  pedido_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          quem_q, quem_d;
  logic          pjogador_q, pjogador_d;
  logic          pdealer_q, pdealer_d;
  logic          feito_q, feito_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= P_OCIOSO;
      cnt_q      <= '0;
      quem_q     <= 1'b0;
      pjogador_q <= 1'b0;
      pdealer_q  <= 1'b0;
      feito_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      quem_q     <= quem_d;
      pjogador_q <= pjogador_d;
      pdealer_q  <= pdealer_d;
      feito_q    <= feito_d;
      timeout_q  <= timeout_d;
    end
  end

  // The counter starts at 1 on phase entry so it counts cycles spent in the phase.
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    quem_d     = quem_q;
    pjogador_d = pjogador_q;
    pdealer_d  = pdealer_q;
    feito_d    = 1'b0;
    timeout_d  = 1'b0;
    case (estado_q)
      P_OCIOSO: begin
        if (go) begin
          quem_d = quem;
          if (!cartaok) begin
            estado_d   = P_PEDE;
            pjogador_d = !quem;
            pdealer_d  = quem;
            cnt_d      = CW'(1);
          end else begin
            estado_d = P_ESPERA_BAIXO;
          end
        end
      end
      P_ESPERA_BAIXO: begin
        if (!cartaok) begin
          estado_d   = P_PEDE;
          pjogador_d = !quem_q;
          pdealer_d  = quem_q;
          cnt_d      = CW'(1);
        end
      end
      P_PEDE: begin
        if (cartaok) begin
          estado_d   = P_SOLTA;
          pjogador_d = 1'b0;
          pdealer_d  = 1'b0;
          cnt_d      = CW'(1);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          estado_d   = P_OCIOSO;
          pjogador_d = 1'b0;
          pdealer_d  = 1'b0;
          timeout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      P_SOLTA: begin
        if (!cartaok) begin
          estado_d = P_OCIOSO;
          feito_d  = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          estado_d  = P_OCIOSO;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: estado_d = P_OCIOSO;
    endcase
  end

  assign pjogador = pjogador_q;
  assign pdealer  = pdealer_q;
  assign feito    = feito_q;
  assign timeout  = timeout_q;

endmodule

// File: rtl/blackjack_controle.sv
// Blackjack game flow: initial deal, player hit/stay, dealer draw rule and outcome.
module blackjack_controle
  import blackjack_pkg::*;
#(
  parameter int unsigned TIMEOUT       = TIMEOUT_PADRAO,
  parameter int unsigned LIMIAR_DEALER = LIMIAR_DEALER_PADRAO
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hit,
  input  logic             stay,
  input  logic             cartaok,
  input  logic [PTS_W-1:0] pts_jogador,
  input  logic [PTS_W-1:0] pts_dealer,
  output logic             pjogador,
  output logic             pdealer,
  output logic             limpa,
  output logic             vez_jog,
  output logic             vitoria,
  output logic             derrota,
  output logic             empate,
  output logic             erro
);

  localparam logic [PTS_W-1:0] LIMIAR = PTS_W'(LIMIAR_DEALER);

  estado_t    estado_q, estado_d;
  logic [1:0] carta_q, carta_d;
  resultado_t res_q, res_d;
  logic       limpa_q, limpa_d;
  logic       vez_jog_q, vez_jog_d;
  logic       go_c, quem_c;
  logic       feito, timeout;

  pedido_carta #(.TIMEOUT(TIMEOUT)) u_pedido (
    .clock    (clock),
    .reset    (reset),
    .go       (go_c),
    .quem     (quem_c),
    .cartaok  (cartaok),
    .pjogador (pjogador),
    .pdealer  (pdealer),
    .feito    (feito),
    .timeout  (timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= E_IDLE;
      carta_q   <= 2'd0;
      res_q     <= '0;
      limpa_q   <= 1'b0;
      vez_jog_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      carta_q   <= carta_d;
      res_q     <= res_d;
      limpa_q   <= limpa_d;
      vez_jog_q <= vez_jog_d;
    end
  end

  // go is withheld while feito/timeout is up so a finished transaction is not restarted.
  always_comb begin
    estado_d = estado_q;
    carta_d  = carta_q;
    res_d    = res_q;
    limpa_d  = 1'b0;
    go_c     = 1'b0;
    quem_c   = 1'b0;
    case (estado_q)
      E_IDLE, E_RESULTADO: begin
        if (start) begin
          res_d    = '0;
          limpa_d  = 1'b1;
          estado_d = E_LIMPA;
        end
      end
      E_LIMPA: begin
        carta_d  = 2'd0;
        estado_d = E_DISTRIBUI;
      end
      E_DISTRIBUI: begin
        quem_c = carta_q[0];
        go_c   = !feito && !timeout;
        if (timeout) begin
          res_d.erro = 1'b1;
          estado_d   = E_RESULTADO;
        end else if (feito) begin
          if (carta_q == 2'd3) begin
            estado_d = (pts_jogador == BLACKJACK) ? E_VEZ_DEALER : E_VEZ_JOG;
          end else begin
            carta_d = carta_q + 2'd1;
          end
        end
      end
      E_VEZ_JOG: begin
        if (hit) begin
          estado_d = E_CARTA_JOG;
        end else if (stay) begin
          estado_d = E_VEZ_DEALER;
        end
      end
      E_CARTA_JOG: begin
        go_c = !feito && !timeout;
        if (timeout) begin
          res_d.erro = 1'b1;
          estado_d   = E_RESULTADO;
        end else if (feito) begin
          if (pts_jogador > BLACKJACK) begin
            res_d.derrota = 1'b1;
            estado_d      = E_RESULTADO;
          end else if (pts_jogador == BLACKJACK) begin
            estado_d = E_VEZ_DEALER;
          end else begin
            estado_d = E_VEZ_JOG;
          end
        end
      end
      E_VEZ_DEALER: begin
        estado_d = (pts_dealer < LIMIAR) ? E_CARTA_DEALER : E_COMPARA;
      end
      E_CARTA_DEALER: begin
        quem_c = 1'b1;
        go_c   = !feito && !timeout;
        if (timeout) begin
          res_d.erro = 1'b1;
          estado_d   = E_RESULTADO;
        end else if (feito) begin
          estado_d = E_VEZ_DEALER;
        end
      end
      E_COMPARA: begin
        estado_d = E_RESULTADO;
        if ((pts_dealer > BLACKJACK) || (pts_jogador > pts_dealer)) begin
          res_d.vitoria = 1'b1;
        end else if (pts_jogador < pts_dealer) begin
          res_d.derrota = 1'b1;
        end else begin
          res_d.empate = 1'b1;
        end
      end
      default: estado_d = E_IDLE;
    endcase
    vez_jog_d = (estado_d == E_VEZ_JOG);
  end

  assign limpa   = limpa_q;
  assign vez_jog = vez_jog_q;
  assign vitoria = res_q.vitoria;
  assign derrota = res_q.derrota;
  assign empate  = res_q.empate;
  assign erro    = res_q.erro;

endmodule

// File: tb/tb_blackjack_controle.sv
// Directed bench for blackjack_controle with a behavioural scoring block and preloaded deck.
module tb_blackjack_controle;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       hit   = 1'b0;
  logic       stay  = 1'b0;
  logic       cartaok;
  logic [5:0] pts_jogador, pts_dealer;
  logic       pjogador, pdealer, limpa, vez_jog, vitoria, derrota, empate, erro;

  int tests  = 0;
  int failed = 0;

  blackjack_controle dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .hit         (hit),
    .stay        (stay),
    .cartaok     (cartaok),
    .pts_jogador (pts_jogador),
    .pts_dealer  (pts_dealer),
    .pjogador    (pjogador),
    .pdealer     (pdealer),
    .limpa       (limpa),
    .vez_jog     (vez_jog),
    .vitoria     (vitoria),
    .derrota     (derrota),
    .empate      (empate),
    .erro        (erro)
  );

  always #5 clock = ~clock;

  // Scoring block model: acks after 2 cycles, keeps cartaok high 2 cycles past release.
  logic [5:0] deck [0:7];
  bit         mute = 1'b0;
  logic [2:0] ptr;
  logic [5:0] soma_j, soma_d;
  logic       as_j, as_d, mquem;
  int         mst, mcnt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cartaok <= 1'b0; ptr <= 3'd0; soma_j <= 6'd0; soma_d <= 6'd0;
      as_j <= 1'b0; as_d <= 1'b0; mquem <= 1'b0; mst <= 0; mcnt <= 0;
    end else begin
      if (limpa) begin
        ptr <= 3'd0; soma_j <= 6'd0; soma_d <= 6'd0; as_j <= 1'b0; as_d <= 1'b0;
      end
      case (mst)
        0: if ((pjogador || pdealer) && !mute) begin mst <= 1; mcnt <= 2; mquem <= pdealer; end
        1: if (mcnt == 0) begin
             cartaok <= 1'b1; mst <= 2; ptr <= ptr + 3'd1;
             if (mquem) begin
               soma_d <= soma_d + deck[ptr];
               if (deck[ptr] == 6'd1) as_d <= 1'b1;
             end else begin
               soma_j <= soma_j + deck[ptr];
               if (deck[ptr] == 6'd1) as_j <= 1'b1;
             end
           end else mcnt <= mcnt - 1;
        2: if (!pjogador && !pdealer) begin mst <= 3; mcnt <= 2; end
        3: if (mcnt == 0) begin cartaok <= 1'b0; mst <= 0; end else mcnt <= mcnt - 1;
        default: mst <= 0;
      endcase
    end
  end

  assign pts_jogador = (as_j && (soma_j + 6'd10 <= 6'd21)) ? soma_j + 6'd10 : soma_j;
  assign pts_dealer  = (as_d && (soma_d + 6'd10 <= 6'd21)) ? soma_d + 6'd10 : soma_d;

  // Request counter and overlap monitor
  int   nreq    = 0;
  bit   overlap = 1'b0;
  logic pj_prev = 1'b0, pd_prev = 1'b0;
  always @(posedge clock) begin
    if ((pjogador && !pj_prev) || (pdealer && !pd_prev)) nreq <= nreq + 1;
    if (pjogador && pdealer) overlap <= 1'b1;
    pj_prev <= pjogador;
    pd_prev <= pdealer;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input logic [5:0] a, b, c, d, e);
    deck[0] = a; deck[1] = b; deck[2] = c; deck[3] = d; deck[4] = e;
    deck[5] = 6'd2; deck[6] = 6'd2; deck[7] = 6'd2;
  endtask

  task automatic pulse_start;
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stay;
    stay = 1'b1; tick(1); stay = 1'b0;
  endtask

  task automatic wait_vez(input int max, output int cyc);
    cyc = 0;
    while (!vez_jog && cyc < max) begin tick(1); cyc++; end
  endtask

  task automatic wait_req(input bit dealer, input int max, output int cyc);
    cyc = 0;
    while (!(dealer ? pdealer : pjogador) && cyc < max) begin tick(1); cyc++; end
  endtask

  task automatic wait_result(input int max, output int cyc, output bit vez_seen);
    cyc = 0; vez_seen = 1'b0;
    while (!(vitoria || derrota || empate || erro) && cyc < max) begin
      if (vez_jog) vez_seen = 1'b1;
      tick(1); cyc++;
    end
  endtask

  task automatic test_reset;
    tick(2);
    tests++;
    if ({pjogador, pdealer, limpa, vez_jog, vitoria, derrota, empate, erro} !== 8'b0) begin
      failed++;
      $display("FAIL reset_held: outputs=%b required=00000000",
               {pjogador, pdealer, limpa, vez_jog, vitoria, derrota, empate, erro});
    end
    reset = 1'b0;
    tick(2);
    tests++;
    if ({pjogador, pdealer, limpa, vez_jog, vitoria, derrota, empate, erro} !== 8'b0) begin
      failed++;
      $display("FAIL reset_idle: outputs=%b required=00000000",
               {pjogador, pdealer, limpa, vez_jog, vitoria, derrota, empate, erro});
    end
  endtask

  task automatic test_vitoria;
    int c; bit vs; int base;
    load(6'd10, 6'd5, 6'd9, 6'd7, 6'd6);
    base = nreq;
    pulse_start;
    tests++;
    if (limpa !== 1'b1) begin failed++; $display("FAIL limpa_t1: got=%b required=1", limpa); end
    tick(1);
    tests++;
    if ({limpa, pjogador} !== 2'b00) begin
      failed++; $display("FAIL t2_quiet: limpa,pjogador=%b required=00", {limpa, pjogador});
    end
    tick(1);
    tests++;
    if (pjogador !== 1'b1) begin failed++; $display("FAIL first_req_t3: got=%b required=1", pjogador); end
    wait_vez(200, c);
    tests++;
    if (c >= 200) begin failed++; $display("FAIL vit_vez_jog: waited=%0d required<200", c); end
    pulse_stay;
    wait_result(400, c, vs);
    tests++;
    if ({vitoria, derrota, empate, erro} !== 4'b1000) begin
      failed++; $display("FAIL vit_result: got=%b required=1000", {vitoria, derrota, empate, erro});
    end
    tests++;
    if (nreq - base != 5) begin failed++; $display("FAIL vit_nreq: got=%0d required=5", nreq - base); end
    tests++;
    if (overlap !== 1'b0) begin failed++; $display("FAIL vit_overlap: got=%b required=0", overlap); end
  endtask

  task automatic test_blackjack_deal;
    int c; bit vs; int base;
    load(6'd1, 6'd9, 6'd10, 6'd8, 6'd5);
    base = nreq;
    pulse_start;
    tests++;
    if ({limpa, vitoria} !== 2'b10) begin
      failed++; $display("FAIL bj_clear: limpa,vitoria=%b required=10", {limpa, vitoria});
    end
    wait_result(400, c, vs);
    tests++;
    if ({vitoria, derrota, empate, erro} !== 4'b1000) begin
      failed++; $display("FAIL bj_result: got=%b required=1000", {vitoria, derrota, empate, erro});
    end
    tests++;
    if (vs !== 1'b0) begin failed++; $display("FAIL bj_skip_vez: vez_jog_seen=%b required=0", vs); end
    tests++;
    if (nreq - base != 4) begin failed++; $display("FAIL bj_nreq: got=%0d required=4", nreq - base); end
  endtask

  task automatic test_bust;
    int c; bit vs; int base;
    load(6'd10, 6'd7, 6'd6, 6'd10, 6'd9);
    base = nreq;
    pulse_start;
    wait_vez(200, c);
    tests++;
    if (c >= 200) begin failed++; $display("FAIL bust_vez_jog: waited=%0d required<200", c); end
    hit = 1'b1; tick(1); hit = 1'b0;
    tests++;
    if (pjogador !== 1'b0) begin failed++; $display("FAIL hit_t1: pjogador=%b required=0", pjogador); end
    tick(1);
    tests++;
    if (pjogador !== 1'b1) begin failed++; $display("FAIL hit_t2: pjogador=%b required=1", pjogador); end
    wait_result(400, c, vs);
    tests++;
    if ({vitoria, derrota, empate, erro} !== 4'b0100) begin
      failed++; $display("FAIL bust_result: got=%b required=0100", {vitoria, derrota, empate, erro});
    end
    tick(8);
    tests++;
    if (nreq - base != 5) begin failed++; $display("FAIL bust_nreq: got=%0d required=5", nreq - base); end
  endtask

  task automatic test_empate;
    int c; bit vs; int base;
    load(6'd10, 6'd10, 6'd8, 6'd8, 6'd3);
    base = nreq;
    pulse_start;
    wait_vez(200, c);
    pulse_stay;
    wait_result(400, c, vs);
    tests++;
    if ({vitoria, derrota, empate, erro} !== 4'b0010) begin
      failed++; $display("FAIL tie_result: got=%b required=0010", {vitoria, derrota, empate, erro});
    end
    tests++;
    if (nreq - base != 4) begin failed++; $display("FAIL tie_nreq: got=%0d required=4", nreq - base); end
  endtask

  task automatic test_timeout;
    int c; bit vs; int k;
    mute = 1'b1;
    load(6'd10, 6'd10, 6'd8, 6'd8, 6'd3);
    pulse_start;
    wait_req(1'b0, 20, c);
    tests++;
    if (c >= 20) begin failed++; $display("FAIL to_req_rise: waited=%0d required<20", c); end
    k = 0;
    while (!erro && k < 200) begin tick(1); k++; end
    tests++;
    if (k != 64) begin failed++; $display("FAIL to_latency: cycles=%0d required=64", k); end
    tests++;
    if ({pjogador, pdealer} !== 2'b00) begin
      failed++; $display("FAIL to_req_low: pjogador,pdealer=%b required=00", {pjogador, pdealer});
    end
    tests++;
    if ({vitoria, derrota, empate, erro} !== 4'b0001) begin
      failed++; $display("FAIL to_flags: got=%b required=0001", {vitoria, derrota, empate, erro});
    end
    mute = 1'b0;
    tick(2);
    pulse_start;
    tests++;
    if ({limpa, erro} !== 2'b10) begin
      failed++; $display("FAIL to_recover: limpa,erro=%b required=10", {limpa, erro});
    end
    wait_vez(200, c);
    tests++;
    if (c >= 200) begin failed++; $display("FAIL to_deal: waited=%0d required<200", c); end
    pulse_stay;
    wait_result(400, c, vs);
    tests++;
    if ({vitoria, derrota, empate, erro} !== 4'b0010) begin
      failed++; $display("FAIL to_rehand: got=%b required=0010", {vitoria, derrota, empate, erro});
    end
  endtask

  task automatic test_reset_mid;
    int c; int base;
    load(6'd10, 6'd5, 6'd9, 6'd7, 6'd6);
    pulse_start;
    wait_req(1'b1, 100, c);
    tests++;
    if (c >= 100) begin failed++; $display("FAIL rm_pdealer: waited=%0d required<100", c); end
    reset = 1'b1;
    #1;
    tests++;
    if ({pjogador, pdealer, limpa, vez_jog, vitoria, derrota, empate, erro} !== 8'b0) begin
      failed++;
      $display("FAIL rm_async: outputs=%b required=00000000",
               {pjogador, pdealer, limpa, vez_jog, vitoria, derrota, empate, erro});
    end
    tick(1);
    reset = 1'b0;
    tick(2);
    base = nreq;
    hit = 1'b1; tick(1); hit = 1'b0;
    stay = 1'b1; tick(1); stay = 1'b0;
    tick(8);
    tests++;
    if ((nreq != base) || ({pjogador, pdealer, vez_jog} !== 3'b000)) begin
      failed++;
      $display("FAIL idle_ignore: new_reqs=%0d outs=%b required=0 000", nreq - base,
               {pjogador, pdealer, vez_jog});
    end
  endtask

  initial begin
    test_reset;
    test_vitoria;
    test_blackjack_deal;
    test_bust;
    test_empate;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
